muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the MIPS datapath.
- Supersedes the combinational hi/lo ALU path: signed/unsigned multiply and divide over STEP bits per cycle, plus MTHI/MTLO writes.
- Exposes a start/busy/done handshake so the controller can stall MFHI/MFLO until the result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- STEP, 1, iterations unrolled per clock; legal values 1, 2, 4; WIDTH % STEP == 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request an operation; sampled every cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  in  WIDTH  rt operand: multiplier or divisor.
- abort  in  1  cancel an in-flight operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- dz  out  1  divide-by-zero flag, valid with done.

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, state IDLE, busy=0, done=0, dz=0. Reset mid-operation discards it; HI/LO are still cleared.
- Reserved op with start: ignored, no state change.
- States:
  - IDLE -> CALC on start with op 000–011.
  - CALC holds N = WIDTH/STEP cycles, then -> FIX.
  - FIX holds 1 cycle, then -> IDLE.
- busy = (state != IDLE).
- Accept rule: start is accepted only when state == IDLE and abort == 0. start while busy is ignored and does not queue.
- MTHI/MTLO:
  - Write hi or lo with a at the accept edge.
  - Visible the next cycle; no busy, no done.
- CALC operands:
  - Captured at the accept edge.
  - Signed ops take absolute values and record the result signs. MIN is treated as unsigned 2^(WIDTH-1).
- Multiply:
  - Radix-2 shift-add, STEP partial-product bits per cycle.
  - 2*WIDTH-bit product accumulated in internal registers.
- Divide:
  - Restoring division, STEP quotient bits per cycle.
  - Quotient and remainder held in internal registers.
- FIX:
  - Apply two's-complement sign correction.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - At the edge leaving FIX, write hi/lo: product {hi,lo}; divide lo=quotient, hi=remainder.
- Latency: accept cycle = cycle 0. hi/lo hold the new result and done=1 in cycle N+2 (34 for WIDTH=32, STEP=1).
- done: high exactly one cycle, the first IDLE cycle after FIX. A new start is legal in that same cycle.
- Divide by zero (b==0, DIV or DIVU):
  - Full latency is still taken.
  - Result lo = all ones, hi = a unmodified; dz=1 alongside done.
  - dz=0 for every other completion.
- Signed overflow: DIV MIN / -1 gives lo=MIN, hi=0, dz=0.
- hi/lo are never modified during CALC or FIX. Reads while busy return the previous values.
- abort:
  - In CALC/FIX: next state IDLE; hi/lo unchanged; no done.
  - abort and start in the same IDLE cycle: abort wins, start not accepted.
  - abort in the same cycle as the FIX->IDLE edge: abort wins, no hi/lo write.

Decomposition:
- Shared package mips_pkg: op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO), state encoding, default WIDTH.
- Sub-module muldiv_step: combinational single iteration, either shift-add or restore-subtract selected by an is_div input. Instantiated STEP times in a generate chain inside muldiv_unit.

Test Plan:
- MULT a=7, b=0xFFFFFFFD -> cycle 34: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=1 for one cycle; busy high cycles 1–33. MULTU same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
- DIVU a=0x12345678, b=0 -> cycle 34: lo=0xFFFFFFFF, hi=0x12345678, dz=1. The next normal op completes with dz=0.
- MTLO 0xA5 in IDLE -> lo=0xA5 next cycle, busy and done stay 0. Start MULT, then pulse start (MTHI) at cycle 5 -> ignored, hi unaffected until the MULT result.
- Start DIV, abort at cycle 10 -> busy=0 at cycle 11, hi/lo keep their prior values, no done. Assert rst_n=0 at cycle 20 of another op -> immediate IDLE, hi=lo=0.
- STEP=4 build: MULT 0x0000FFFF*0x0000FFFF -> done at cycle 10, hi=0, lo=0xFFFE0001. Back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: hi/lo unit opcodes, unit FSM states and helper decoders.
package mips_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Multiply and divide opcodes all live in the lower half of the encoding.
  function automatic logic is_calc_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the hi/lo unit: shift-add multiply or restoring divide.
module muldiv_step
  import mips_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted = {hi_in, lo_in[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    hi_out  = sum[WIDTH:1];
    lo_out  = {sum[0], lo_in[WIDTH-1:1]};
    if (is_div) begin
      // Remainder stays below the divisor, so bit WIDTH of diff is the borrow.
      if (!diff[WIDTH]) begin
        hi_out = diff[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_out = shifted[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair; STEP iterations per clock.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Handshake: start is taken only in IDLE with abort low; busy spans CALC and FIX;
  // done pulses in the first IDLE cycle after FIX, and that cycle may accept a new start.
  md_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  logic [WIDTH-1:0] chain_hi [STEP+1];
  logic [WIDTH-1:0] chain_lo [STEP+1];

  assign chain_hi[0] = acc_hi_q;
  assign chain_lo[0] = acc_lo_q;

  for (genvar g = 0; g < STEP; g++) begin : g_step
    muldiv_step #(
      .WIDTH (WIDTH)
    ) u_step (
      .is_div (is_div_q),
      .hi_in  (chain_hi[g]),
      .lo_in  (chain_lo[g]),
      .opnd   (opnd_q),
      .hi_out (chain_hi[g+1]),
      .lo_out (chain_lo[g+1])
    );
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    accept  = (state_q == ST_IDLE) && start && !abort;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_calc_op(op)) begin
          state_d = ST_CALC;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = done_q;
    dz   = dz_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // Operands become magnitudes; MIN stays MIN, read as unsigned 2^(WIDTH-1).
  always_comb begin
    op_signed = is_signed_op(op);
    a_neg     = op_signed && a[WIDTH-1];
    b_neg     = op_signed && b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  always_comb begin
    prod_mag = {acc_hi_q, acc_lo_q};
    prod_fix = neg_res_q ? -prod_mag : prod_mag;
    rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
    // A zero divisor shifts the dividend magnitude into the remainder, so rem_fix is a itself.
    quo_fix  = dz_pend_q ? {WIDTH{1'b1}} : (neg_res_q ? -acc_lo_q : acc_lo_q);
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_pend_d = dz_pend_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    if (accept) begin
      if (is_calc_op(op)) begin
        is_div_d  = is_div_op(op);
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        dz_pend_d = is_div_op(op) && (b == '0);
        acc_hi_d  = '0;
        if (is_div_op(op)) begin
          acc_lo_d = a_mag;
          opnd_d   = b_mag;
        end else begin
          acc_lo_d = b_mag;
          opnd_d   = a_mag;
        end
      end else if (op == OP_MTHI) begin
        hi_d = a;
      end else if (op == OP_MTLO) begin
        lo_d = a;
      end
    end

    if (state_q == ST_CALC && !abort) begin
      acc_hi_d = chain_hi[STEP];
      acc_lo_d = chain_lo[STEP];
    end

    if (state_q == ST_FIX && !abort) begin
      done_d = 1'b1;
      dz_d   = dz_pend_q;
      if (is_div_q) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: STEP=1 main instance plus a STEP=4 instance.
module tb_muldiv_unit;
  import mips_pkg::*;

  localparam int W  = 32;
  localparam int N1 = 32;
  localparam int N4 = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo;
  logic         busy, done, dz;

  logic         s4_start, s4_abort;
  logic [2:0]   s4_op;
  logic [W-1:0] s4_a, s4_b;
  logic [W-1:0] s4_hi, s4_lo;
  logic         s4_busy, s4_done, s4_dz;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] pre_hi = '0;
  logic [W-1:0] pre_lo = '0;

  logic [2*W:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [2*W:0] exp4_q[$];
  int           exp4_cyc_q[$];

  muldiv_unit #(.WIDTH(W), .STEP(1)) u_dut (
    .clk (clk), .rst_n (rst_n), .start (start), .op (op), .a (a), .b (b),
    .abort (abort), .hi (hi), .lo (lo), .busy (busy), .done (done), .dz (dz)
  );

  muldiv_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .start (s4_start), .op (s4_op), .a (s4_a), .b (s4_b),
    .abort (s4_abort), .hi (s4_hi), .lo (s4_lo), .busy (s4_busy), .done (s4_done), .dz (s4_dz)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: MIPS semantics in plain 64-bit arithmetic. Returns {dz, hi, lo}.
  function automatic logic [2*W:0] ref_result(input logic [2:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
    logic [63:0] p, qv, rv;
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      OP_MULT:  p = sx * sy;
      OP_MULTU: p = {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        if (y == '0) return {1'b1, x, 32'hFFFF_FFFF};
        qv = sx / sy;
        rv = sx % sy;
        p  = {rv[31:0], qv[31:0]};
      end
      OP_DIVU: begin
        if (y == '0) return {1'b1, x, 32'hFFFF_FFFF};
        p = {x % y, x / y};
      end
      default: p = {m_hi, m_lo};
    endcase
    return {1'b0, p};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [2*W:0] e;
    int c;
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("result_hi", 64'(hi), 64'(e[63:32]));
          check("result_lo", 64'(lo), 64'(e[31:0]));
          check("result_dz", 64'(dz), 64'(e[64]));
          check("done_cycle", 64'(cyc), 64'(c));
        end
      end
      if (s4_done) begin
        if (exp4_q.size() == 0) begin
          check("s4_unexpected_done", 64'(s4_done), 64'd0);
        end else begin
          e = exp4_q.pop_front();
          c = exp4_cyc_q.pop_front();
          check("s4_result_hi", 64'(s4_hi), 64'(e[63:32]));
          check("s4_result_lo", 64'(s4_lo), 64'(e[31:0]));
          check("s4_result_dz", 64'(s4_dz), 64'(e[64]));
          check("s4_done_cycle", 64'(cyc), 64'(c));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit expect_result);
    logic [2*W:0] r;
    pre_hi = m_hi;
    pre_lo = m_lo;
    op = o; a = x; b = y; start = 1'b1;
    if (o[2] == 1'b0) begin
      if (expect_result) begin
        r = ref_result(o, x, y);
        exp_q.push_back(r);
        exp_cyc_q.push_back(cyc + N1 + 2);
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
    end else if (o == OP_MTHI) begin
      m_hi = x;
    end else if (o == OP_MTLO) begin
      m_lo = x;
    end
    tick();
    start = 1'b0;
    if (o[2] == 1'b1) begin
      check("mt_hi", 64'(hi), 64'(m_hi));
      check("mt_lo", 64'(lo), 64'(m_lo));
      check("mt_busy", 64'(busy), 64'd0);
      check("mt_done", 64'(done), 64'd0);
    end
  endtask

  // Runs until busy drops (the done cycle); hi/lo must hold their old values meanwhile.
  task automatic wait_idle(output int busy_cycles);
    bit stable = 1'b1;
    busy_cycles = 0;
    while (busy && busy_cycles < 200) begin
      if (hi !== pre_hi || lo !== pre_lo) stable = 1'b0;
      busy_cycles++;
      tick();
    end
    check("idle_reached", 64'(busy), 64'd0);
    check("hold_while_busy", 64'(stable), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc;
    logic [W-1:0] x, y;
    logic [2:0] o;
    logic [2*W:0] r;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
    s4_start = 1'b0; s4_abort = 1'b0; s4_op = '0; s4_a = '0; s4_b = '0;
    tick(); tick();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    rst_n = 1'b1;
    tick();

    // Signed/unsigned multiply, the second issued in the done cycle of the first.
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1);
    check("mult_busy_start", 64'(busy), 64'd1);
    wait_idle(bc);
    check("mult_busy_cycles", 64'(bc), 64'(N1 + 1));
    issue(OP_MULTU, 32'd7, 32'hFFFF_FFFD, 1'b1);
    wait_idle(bc);

    issue(OP_DIVU, 32'd100, 32'd7, 1'b1);              wait_idle(bc);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);          wait_idle(bc);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  wait_idle(bc);
    issue(OP_DIVU, 32'h1234_5678, 32'd0, 1'b1);         wait_idle(bc);
    issue(OP_MULT, 32'd3, 32'd5, 1'b1);                 wait_idle(bc);

    tick();
    issue(OP_MTLO, 32'h0000_00A5, 32'd0, 1'b0);

    // MTHI pulsed while a multiply is in flight must be dropped.
    issue(OP_MULT, 32'h0001_2345, 32'hFFFF_0000, 1'b1);
    repeat (4) tick();
    op = OP_MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0;
    check("ignored_mthi_hi", 64'(hi), 64'(pre_hi));
    wait_idle(bc);

    // abort together with start in IDLE: nothing accepted.
    tick();
    op = OP_MULT; a = 32'd9; b = 32'd9; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'd0);

    // abort in CALC at cycle 10.
    issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_calc_busy", 64'(busy), 64'd0);
    check("abort_calc_hi", 64'(hi), 64'(m_hi));
    check("abort_calc_lo", 64'(lo), 64'(m_lo));

    // abort on the FIX->IDLE edge: no write, no done.
    issue(OP_DIVU, 32'd77, 32'd5, 1'b0);
    repeat (32) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_fix_busy", 64'(busy), 64'd0);
    check("abort_fix_done", 64'(done), 64'd0);
    check("abort_fix_hi", 64'(hi), 64'(m_hi));
    check("abort_fix_lo", 64'(lo), 64'(m_lo));
    repeat (3) tick();

    // Asynchronous reset at cycle 20 of a multiply.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (19) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midop_rst_busy", 64'(busy), 64'd0);
    check("midop_rst_hi", 64'(hi), 64'd0);
    check("midop_rst_lo", 64'(lo), 64'd0);
    m_hi = '0;
    m_lo = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Random ops, with occasional back-to-back issue in the done cycle.
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = rand_operand();
      y = rand_operand();
      issue(o, x, y, 1'b1);
      if (o[2] == 1'b0) wait_idle(bc);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) tick();
    end

    // STEP=4 instance: 8 CALC cycles, done at cycle 10, back-to-back accepted.
    s4_op = OP_MULT; s4_a = 32'h0000_FFFF; s4_b = 32'h0000_FFFF; s4_start = 1'b1;
    exp4_q.push_back(ref_result(OP_MULT, 32'h0000_FFFF, 32'h0000_FFFF));
    exp4_cyc_q.push_back(cyc + N4 + 2);
    tick();
    s4_start = 1'b0;
    for (int k = 0; k < 50 && s4_busy; k++) tick();
    check("s4_idle_reached", 64'(s4_busy), 64'd0);
    x = W'($urandom);
    y = W'($urandom);
    r = ref_result(OP_DIV, x, y);
    s4_op = OP_DIV; s4_a = x; s4_b = y; s4_start = 1'b1;
    exp4_q.push_back(r);
    exp4_cyc_q.push_back(cyc + N4 + 2);
    tick();
    s4_start = 1'b0;
    for (int k = 0; k < 50 && s4_busy; k++) tick();
    check("s4_idle_reached", 64'(s4_busy), 64'd0);

    repeat (5) tick();
    check("queue_drained", 64'(exp_q.size() + exp4_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
